// File: rtl/lsu_store_buffer.sv
// ---------------------------------------------------------------------------
// lsu_store_buffer
//   Word store buffer between the exu store/load path and the dccm write port.
//   Stores are queued in a circular FIFO, drained to the dccm in order, and
//   forwarded to loads that hit a buffered word address (youngest wins).
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   st_valid/st_ready    store handshake; st_addr (byte addr), st_data (word)
//   ld_valid, ld_addr    load lookup; ld_hit, ld_data forwarded result
//   drain_en             drain permitted this cycle
//   dccm_wen/waddr/wdata head-entry write to the dccm (combinational)
//   sb_empty, sb_count   occupancy status
// ---------------------------------------------------------------------------
module lsu_store_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [XLEN-1:0]          st_addr,
  input  logic [XLEN-1:0]          st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [XLEN-1:0]          ld_addr,
  output logic                     ld_hit,
  output logic [XLEN-1:0]          ld_data,
  input  logic                     drain_en,
  output logic                     dccm_wen,
  output logic [XLEN-1:0]          dccm_waddr,
  output logic [XLEN-1:0]          dccm_wdata,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AW    = XLEN - 2;

  // Entry storage: word address and data; only the valid bits are reset.
  logic [AW-1:0]    r_addr [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_ld_word;
  logic [PTR_W-1:0] w_idx;
  logic             w_hit;
  logic [XLEN-1:0]  w_fwd;

  // Handshake and drain strobes; a full buffer refuses stores even while draining.
  assign st_ready   = (r_count != CNT_W'(DEPTH));
  assign w_push     = st_valid & st_ready;
  assign dccm_wen   = drain_en & (r_count != '0);
  assign w_pop      = dccm_wen;
  assign dccm_waddr = {r_addr[r_rd_ptr], 2'b00};
  assign dccm_wdata = r_data[r_rd_ptr];
  assign sb_empty   = (r_count == '0);
  assign sb_count   = r_count;

  // Entry payload write; payload needs no reset because valid bits gate use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr[XLEN-1:2];
      r_data[r_wr_ptr] <= st_data;
    end
  end

  // Pointers, occupancy and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
        r_valid[r_wr_ptr]  <= 1'b1;
      end
      // Push never targets the head slot while it is popped: push needs
      // non-full and pop needs non-empty, so wr_ptr != rd_ptr here.
      if (w_pop) begin
        r_rd_ptr           <= r_rd_ptr + PTR_W'(1);
        r_valid[r_rd_ptr]  <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Load forwarding: scan oldest to youngest so the youngest match wins.
  // Uses registered entries only, so a same-cycle store is never forwarded,
  // while the entry being drained this cycle still participates.
  always_comb begin
    w_hit     = 1'b0;
    w_fwd     = '0;
    w_idx     = '0;
    w_ld_word = ld_addr[XLEN-1:2];
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if (ld_valid && r_valid[w_idx] && (r_addr[w_idx] == w_ld_word)) begin
        w_hit = 1'b1;
        w_fwd = r_data[w_idx];
      end
    end
  end

  assign ld_hit  = w_hit;
  assign ld_data = w_fwd;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_lsu_store_buffer
//   Self-checking bench: directed scenarios plus random traffic, compared each
//   cycle against a queue-based reference model of the store buffer.
// ---------------------------------------------------------------------------
module tb_lsu_store_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            st_valid;
  logic [XLEN-1:0] st_addr;
  logic [XLEN-1:0] st_data;
  logic            st_ready;
  logic            ld_valid;
  logic [XLEN-1:0] ld_addr;
  logic            ld_hit;
  logic [XLEN-1:0] ld_data;
  logic            drain_en;
  logic            dccm_wen;
  logic [XLEN-1:0] dccm_waddr;
  logic [XLEN-1:0] dccm_wdata;
  logic            sb_empty;
  logic [CW-1:0]   sb_count;

  lsu_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .drain_en   (drain_en),
    .dccm_wen   (dccm_wen),
    .dccm_waddr (dccm_waddr),
    .dccm_wdata (dccm_wdata),
    .sb_empty   (sb_empty),
    .sb_count   (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of buffered stores, index 0 = oldest.
  typedef struct {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t q[$];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_all();
    logic            e_hit;
    logic [XLEN-1:0] e_data;
    int              n;
    n      = q.size();
    e_hit  = 1'b0;
    e_data = '0;
    if (ld_valid) begin
      foreach (q[i]) begin
        if ((q[i].addr >> 2) == (ld_addr >> 2)) begin
          e_hit  = 1'b1;
          e_data = q[i].data;
        end
      end
    end
    chk("st_ready", XLEN'(st_ready), XLEN'(n != DEPTH));
    chk("sb_count", XLEN'(sb_count), XLEN'(n));
    chk("sb_empty", XLEN'(sb_empty), XLEN'(n == 0));
    chk("dccm_wen", XLEN'(dccm_wen), XLEN'(drain_en && n != 0));
    if (drain_en && n != 0) begin
      chk("dccm_waddr", dccm_waddr, q[0].addr & ~XLEN'(3));
      chk("dccm_wdata", dccm_wdata, q[0].data);
    end
    chk("ld_hit", XLEN'(ld_hit), XLEN'(e_hit));
    chk("ld_data", ld_data, e_data);
  endtask

  // One cycle: check at negedge, advance model, drive window opens at posedge+1.
  task automatic step();
    bit push;
    bit pop;
    ent_t e;
    @(negedge clk);
    check_all();
    push = st_valid && (q.size() != DEPTH);
    pop  = drain_en && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      e.addr = st_addr;
      e.data = st_data;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [XLEN-1:0] sa, input logic [XLEN-1:0] sd,
                       input logic lv, input logic [XLEN-1:0] la, input logic de);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
    drain_en = de;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 32'h0, 1'b1);
    #1;
    // Reset state
    chk("rst_st_ready", XLEN'(st_ready), 1);
    chk("rst_dccm_wen", XLEN'(dccm_wen), 0);
    chk("rst_ld_hit", XLEN'(ld_hit), 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_sb_empty", XLEN'(sb_empty), 1);
    chk("rst_sb_count", XLEN'(sb_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single store then drain next cycle
    drive(1'b1, 32'h100, 32'hAAAA5555, 1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    #1;
    chk("d1_wen", XLEN'(dccm_wen), 1);
    chk("d1_waddr", dccm_waddr, 32'h100);
    chk("d1_wdata", dccm_wdata, 32'hAAAA5555);
    step();
    chk("d1_empty", XLEN'(sb_empty), 1);

    // Fill with drain off, 5th refused, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, XLEN'(i * 4), XLEN'(32'h1000 + i), 1'b0, '0, 1'b0);
      step();
    end
    chk("full_ready", XLEN'(st_ready), 0);
    chk("full_count", XLEN'(sb_count), 4);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ord_waddr", dccm_waddr, XLEN'(i * 4));
      step();
    end
    chk("ord_empty", XLEN'(sb_empty), 1);

    // Duplicate address forwarding, youngest wins
    drive(1'b1, 32'h20, 32'h1, 1'b0, '0, 1'b0);
    step();
    drive(1'b1, 32'h20, 32'h2, 1'b0, '0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 32'h23, 1'b0);
    #1;
    chk("fwd_hit", XLEN'(ld_hit), 1);
    chk("fwd_data", ld_data, 32'h2);
    step();
    drive(1'b0, '0, '0, 1'b1, 32'h24, 1'b0);
    #1;
    chk("fwd_miss_hit", XLEN'(ld_hit), 0);
    chk("fwd_miss_data", ld_data, 0);
    step();
    // Same-cycle store must not forward
    drive(1'b1, 32'h40, 32'h77, 1'b1, 32'h40, 1'b0);
    #1;
    chk("nofwd_same", XLEN'(ld_hit), 0);
    step();

    // Full + drain + store: refused, then next cycle enqueue+drain holds count
    drive(1'b1, 32'h50, 32'h5, 1'b0, '0, 1'b0);
    step();
    drive(1'b1, 32'h60, 32'h6, 1'b1, 32'h20, 1'b1);
    #1;
    chk("fd_ready0", XLEN'(st_ready), 0);
    step();
    chk("fd_ready1", XLEN'(st_ready), 1);
    step();
    chk("fd_count3", XLEN'(sb_count), 3);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (4) step();

    // Wrap: 10 stores with continuous drain
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, XLEN'(32'h200 + i * 4), $urandom, 1'b1, XLEN'(32'h200 + (i - 1) * 4), 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (3) step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0),
            XLEN'(32'h80 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3)),
            $urandom,
            1'($urandom_range(0, 1)),
            XLEN'(32'h80 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3)),
            1'($urandom_range(0, 2) == 0));
      step();
    end

    // Reset mid-drain with 3 entries
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, XLEN'(32'h300 + i * 4), XLEN'(32'hC0 + i), 1'b0, '0, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b1, 32'h308, 1'b1);
    step();
    chk("mid_count3", XLEN'(sb_count), 3);
    chk("mid_wen", XLEN'(dccm_wen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wen", XLEN'(dccm_wen), 0);
    chk("ar_empty", XLEN'(sb_empty), 1);
    chk("ar_count", XLEN'(sb_count), 0);
    chk("ar_ready", XLEN'(st_ready), 1);
    chk("ar_ld_hit", XLEN'(ld_hit), 0);
    chk("ar_ld_data", ld_data, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    // First enqueue right after release
    drive(1'b1, 32'h400, 32'hBEEF, 1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
